kbd_keymap_tracker: RTL and testbench
=====================================

Name: kbd_keymap_tracker

Overview:
- Parametrised successor to the fixed four-arrow keyboard controller.
- Consumes the byte stream from the PS/2 receiver and tracks held state for NUM_KEYS mapped keys, with full set-2 prefix handling (E0 extended, F0 break, E1 pause).
- Emits per-key press/release pulses and clears state on keyboard self-test.
- Sits between the PS/2 receiver and the game/control logic.

Parameters:
- NUM_KEYS, 4, number of tracked keys (1..32).
- KEYMAP, {1'b1,8'h6B,1'b1,8'h74,1'b1,8'h72,1'b1,8'h75}, NUM_KEYS*9 bits. Entry i is KEYMAP[i*9+:9]: bit 8 = extended flag, bits 7:0 = scan code. The default maps 0=up, 1=down, 2=right, 3=left.
- TIMEOUT_CYCLES, 1_000_000, prefix-stale timeout; used only with the optional feature.

Ports:
- clk_50  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- byte_valid  in  1  one-cycle strobe: byte_data is a new received byte.
- byte_data  in  8  received scan byte.
- keys_held  out  NUM_KEYS  level: bit i is set while key i is down.
- key_press  out  NUM_KEYS  one-cycle pulse on a 0->1 transition of keys_held[i].
- key_release  out  NUM_KEYS  one-cycle pulse on a 1->0 transition of keys_held[i].
- any_held  out  1  OR-reduction of keys_held (registered).
- last_code  out  9  {ext, code} of the last completed make/break event, mapped or not.
- seq_error  out  1  one-cycle pulse on protocol anomaly.

Behaviour:
- Reset (rst_n=0 at a clk_50 edge):
  - keys_held, key_press, key_release, any_held, last_code and seq_error all go to 0.
  - FSM goes to IDLE; the E1 skip counter goes to 0.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Bytes are evaluated only when byte_valid=1.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE with skip count = 7.
    - AA (BAT pass) -> clear all keys_held. Each cleared bit raises its key_release pulse. Stay in IDLE.
    - FA/FE/EE (ack/resend/echo) -> ignored.
    - 00/FF (overrun) -> seq_error pulse, stay in IDLE.
    - Any other byte -> make event, ext=0.
  - EXT:
    - F0 -> EXT_BRK.
    - 12 (fake shift) -> ignored, back to IDLE.
    - E0/E1 -> seq_error pulse, stay in EXT.
    - Any other byte -> make event, ext=1, then IDLE.
  - BRK:
    - E0/F0/E1 -> seq_error pulse, IDLE.
    - Any other byte -> break event, ext=0, then IDLE.
  - EXT_BRK:
    - 12 -> ignored, IDLE.
    - E0/F0/E1 -> seq_error pulse, IDLE.
    - Any other byte -> break event, ext=1, then IDLE.
  - PAUSE: each valid byte decrements the skip count. At 0 -> IDLE. No key events are generated.
- Event application: for each i where {ext, code} == KEYMAP entry i:
  - a make event sets keys_held[i];
  - a break event clears keys_held[i].
  - If the map has duplicate entries, every matching index updates.
  - Unmapped codes update only last_code.
- Latency: for the byte strobed at cycle N, keys_held, last_code, the pulses and seq_error are valid at N+1. any_held is valid at N+2 (it follows keys_held by one cycle).
- Edge pulses: key_press[i] = (new held & ~old held); key_release[i] = (~new held & old held). Typematic repeat makes for an already-held key change nothing and produce no pulse.
- Back-to-back byte_valid on consecutive cycles is fully supported with no drop. No back-pressure exists.
- Reset mid-sequence (e.g. after E0 F0): the FSM returns to IDLE and the pending prefix is discarded.

Optional Feature:
- Macro: KBD_PREFIX_TIMEOUT_EN.
- Defined:
  - A counter runs while the FSM is in EXT, BRK, EXT_BRK or PAUSE. It resets on every byte_valid.
  - When the counter reaches TIMEOUT_CYCLES, the FSM forces IDLE and pulses seq_error for 1 cycle.
  - The counter is cleared by rst_n.
- Not defined: no counter logic exists. Prefix states wait indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Reset, then bytes E0,75 -> keys_held=4'b0001 and key_press=4'b0001 for one cycle, both at N+1 after byte 75; last_code=9'h175.
- E0,75 then E0,75 (typematic), then E0,F0,75 -> keys_held stays 0001 with no second press pulse. After the break: keys_held=0000, key_release=0001 for one cycle.
- Hold up+left (E0,75 and E0,6B), then byte AA -> keys_held=0000 and key_release=1001 in the same cycle.
- Bytes 75 (non-extended keypad 8), then F0,75 -> keys_held stays 0000; last_code=9'h075, then 9'h075 again.
- E1,14,77,E1,F0,14,F0,77 then E0,72 -> no events during the pause sequence; the subsequent E0,72 sets keys_held=0010.
- With KBD_PREFIX_TIMEOUT_EN and TIMEOUT_CYCLES=16: byte E0, idle 16 cycles, then 72 -> seq_error pulses once and 72 is treated as a non-extended make, so keys_held=0000. Without the macro, the same stimulus gives keys_held=0010.

Source files
------------

// File: rtl/kbd_keymap_tracker.sv
// kbd_keymap_tracker: turns the PS/2 set-2 scan byte stream into held state
//   for NUM_KEYS mapped keys. Decodes the E0 (extended), F0 (break) and E1
//   (pause) prefixes and emits per-key press/release pulses.
// Latency: keys_held, key_press, key_release, last_code and seq_error are
//   updated one cycle after the byte strobe. any_held follows keys_held one
//   cycle later.
// Backpressure: none. A byte can be accepted on every cycle.
// Optional feature: define KBD_PREFIX_TIMEOUT_EN to abandon a stale prefix
//   after TIMEOUT_CYCLES cycles with no byte. seq_error pulses when this happens.
// Ports:
//   clk_50      - clock; all logic uses the rising edge
//   rst_n       - synchronous reset, active low
//   byte_valid  - one-cycle strobe that qualifies byte_data
//   byte_data   - received scan byte
//   keys_held   - level, one bit per mapped key
//   key_press   - one-cycle pulse when a key goes down
//   key_release - one-cycle pulse when a key goes up
//   any_held    - registered OR of keys_held
//   last_code   - {ext, code} of the last make or break event
//   seq_error   - one-cycle pulse on a protocol anomaly
module kbd_keymap_tracker #(
  parameter int                      NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*9-1:0]   KEYMAP         = {1'b1, 8'h6B, 1'b1, 8'h74,
                                                       1'b1, 8'h72, 1'b1, 8'h75},
  parameter int                      TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk_50,
  input  logic                rst_n,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic [NUM_KEYS-1:0] keys_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_held,
  output logic [8:0]          last_code,
  output logic                seq_error
);

  // Catch bad parameter values at elaboration.
  if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : g_bad_num_keys
    $error("kbd_keymap_tracker: NUM_KEYS must be in 1..32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("kbd_keymap_tracker: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t     state;
  logic [2:0] skip_cnt;
  logic       timeout_hit;

  // Compare the current byte against every map entry, once with the extended
  // flag clear and once with it set. The FSM chooses which vector applies.
  // Duplicate map entries therefore update every matching index.
  logic [NUM_KEYS-1:0] match_base;
  logic [NUM_KEYS-1:0] match_ext;

  always_comb begin
    match_base = '0;
    match_ext  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (KEYMAP[i*9 +: 9] == {1'b0, byte_data}) match_base[i] = 1'b1;
      if (KEYMAP[i*9 +: 9] == {1'b1, byte_data}) match_ext[i]  = 1'b1;
    end
  end

`ifdef KBD_PREFIX_TIMEOUT_EN
  // This counter counts cycles with no byte while a prefix is pending.
  // A byte or a return to IDLE clears it.
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state != S_IDLE) && !byte_valid &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (byte_valid || state == S_IDLE || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Prefix FSM with registered key state, pulses and error flag.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      skip_cnt    <= 3'd0;
      keys_held   <= '0;
      key_press   <= '0;
      key_release <= '0;
      any_held    <= 1'b0;
      last_code   <= 9'd0;
      seq_error   <= 1'b0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      seq_error   <= 1'b0;
      any_held    <= |keys_held;

      if (byte_valid) begin
        unique case (state)
          S_IDLE: begin
            case (byte_data)
              8'hE0: state <= S_EXT;
              8'hF0: state <= S_BRK;
              8'hE1: begin
                state    <= S_PAUSE;
                skip_cnt <= 3'd7;
              end
              8'hAA: begin
                // Keyboard passed self-test, so every key is released.
                keys_held   <= '0;
                key_release <= keys_held;
              end
              8'hFA, 8'hFE, 8'hEE: begin
              end
              8'h00, 8'hFF: seq_error <= 1'b1;
              default: begin
                keys_held <= keys_held | match_base;
                key_press <= match_base & ~keys_held;
                last_code <= {1'b0, byte_data};
              end
            endcase
          end

          S_EXT: begin
            case (byte_data)
              8'hF0: state <= S_EXT_BRK;
              8'h12: state <= S_IDLE;      // fake shift from the keyboard
              8'hE0, 8'hE1: seq_error <= 1'b1;
              default: begin
                keys_held <= keys_held | match_ext;
                key_press <= match_ext & ~keys_held;
                last_code <= {1'b1, byte_data};
                state     <= S_IDLE;
              end
            endcase
          end

          S_BRK: begin
            case (byte_data)
              8'hE0, 8'hF0, 8'hE1: seq_error <= 1'b1;
              default: begin
                keys_held   <= keys_held & ~match_base;
                key_release <= match_base & keys_held;
                last_code   <= {1'b0, byte_data};
              end
            endcase
            state <= S_IDLE;
          end

          S_EXT_BRK: begin
            case (byte_data)
              8'h12: begin
              end
              8'hE0, 8'hF0, 8'hE1: seq_error <= 1'b1;
              default: begin
                keys_held   <= keys_held & ~match_ext;
                key_release <= match_ext & keys_held;
                last_code   <= {1'b1, byte_data};
              end
            endcase
            state <= S_IDLE;
          end

          S_PAUSE: begin
            // Drop the 7 bytes that follow E1 without generating events.
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt <= 3'd1) state <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end else if (timeout_hit) begin
        state     <= S_IDLE;
        skip_cnt  <= 3'd0;
        seq_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kbd_keymap_tracker.sv
// Bench for kbd_keymap_tracker. A driver applies directed sequences and random
// byte streams, and queues the outputs the reference model predicts for each
// cycle. A monitor pops one prediction per cycle and compares it with the DUT
// outputs.
module tb_kbd_keymap_tracker;

  localparam int          NK = 4;
  localparam logic [35:0] KM = {1'b1, 8'h6B, 1'b1, 8'h74, 1'b1, 8'h72, 1'b1, 8'h75};
  localparam int          TO = 16;

  logic          clk_50 = 1'b0;
  logic          rst_n;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic [NK-1:0] keys_held;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          any_held;
  logic [8:0]    last_code;
  logic          seq_error;

  always #5 clk_50 = ~clk_50;

  kbd_keymap_tracker #(
    .NUM_KEYS      (NK),
    .KEYMAP        (KM),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_50     (clk_50),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .keys_held  (keys_held),
    .key_press  (key_press),
    .key_release(key_release),
    .any_held   (any_held),
    .last_code  (last_code),
    .seq_error  (seq_error)
  );

  typedef struct packed {
    logic [NK-1:0] held;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic          any;
    logic [8:0]    code;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc_no = 0;

  // Reference model state. The pending prefix is held as flags plus a count of
  // pause bytes still to drop.
  bit [NK-1:0] m_held;
  bit [8:0]    m_code;
  bit          m_ext;
  bit          m_brk;
  int          m_pause;
  int          m_idle;

  function automatic bit [NK-1:0] lookup(input bit ext, input bit [7:0] b);
    bit [35:0]   km = KM;
    bit [NK-1:0] m  = '0;
    for (int i = 0; i < NK; i++)
      if (km[i*9 +: 9] == {ext, b}) m[i] = 1'b1;
    return m;
  endfunction

  task automatic key_event(input bit make, input bit ext, input bit [7:0] b);
    bit [NK-1:0] m = lookup(ext, b);
    m_code = {ext, b};
    if (make) m_held = m_held | m;
    else      m_held = m_held & ~m;
  endtask

  task automatic model_step(input bit rst, input bit vld, input bit [7:0] b);
    exp_t        e;
    bit [NK-1:0] prev;
    e = '0;
    if (!rst) begin
      m_held = '0; m_code = '0; m_ext = 0; m_brk = 0; m_pause = 0; m_idle = 0;
      exp_q.push_back(e);
      return;
    end
    e.any = |m_held;
    prev  = m_held;
    if (vld) begin
      m_idle = 0;
      if (m_pause > 0) begin
        m_pause--;
      end else if (!m_ext && !m_brk) begin
        if (b == 8'hE0)                      m_ext = 1;
        else if (b == 8'hF0)                 m_brk = 1;
        else if (b == 8'hE1)                 m_pause = 7;
        else if (b == 8'hAA)                 m_held = '0;
        else if (b inside {8'hFA, 8'hFE, 8'hEE}) ;
        else if (b inside {8'h00, 8'hFF})    e.err = 1;
        else                                 key_event(1, 0, b);
      end else if (!m_brk) begin
        if (b == 8'hF0)                      m_brk = 1;
        else if (b == 8'h12)                 m_ext = 0;
        else if (b inside {8'hE0, 8'hE1})    e.err = 1;
        else begin key_event(1, 1, b); m_ext = 0; end
      end else begin
        if (b inside {8'hE0, 8'hF0, 8'hE1})  e.err = 1;
        else if (!(m_ext && b == 8'h12))     key_event(0, m_ext, b);
        m_ext = 0;
        m_brk = 0;
      end
    end
`ifdef KBD_PREFIX_TIMEOUT_EN
    else if (m_ext || m_brk || m_pause > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_ext = 0; m_brk = 0; m_pause = 0; m_idle = 0;
        e.err = 1;
      end
    end
`endif
    e.held  = m_held;
    e.press = m_held & ~prev;
    e.rel   = ~m_held & prev;
    e.code  = m_code;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus, applied away from the rising edge.
  task automatic cyc(input bit rst, input bit vld, input bit [7:0] b);
    @(negedge clk_50);
    rst_n      = rst;
    byte_valid = vld;
    byte_data  = b;
    model_step(rst, vld, b);
  endtask

  task automatic send(input bit [7:0] b);
    cyc(1, 1, b);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 8'($urandom_range(0, 255)));
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h, required %0h", name, cyc_no, act, req);
  endtask

  // Monitor: one queued prediction covers each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_50);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("keys_held",   9'(keys_held),   9'(e.held));
        chk("key_press",   9'(key_press),   9'(e.press));
        chk("key_release", 9'(key_release), 9'(e.rel));
        chk("any_held",    9'(any_held),    9'(e.any));
        chk("last_code",   last_code,       e.code);
        chk("seq_error",   9'(seq_error),   9'(e.err));
      end
    end
  end

  initial begin
    bit [7:0] tbl [14];
    tbl = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h12,
            8'h75, 8'h72, 8'h6B, 8'h74, 8'h75, 8'hE0};
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    m_held = '0; m_code = '0; m_ext = 0; m_brk = 0; m_pause = 0; m_idle = 0;

    repeat (3) cyc(0, 0, 8'h00);
    idle(2);

    // Extended up arrow: press.
    send(8'hE0); send(8'h75); idle(2);
    // Typematic repeat, then release.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(2);
    // Hold up and left, then self-test pass clears both.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h6B); send(8'hAA); idle(2);
    // Non-extended 75 is unmapped.
    send(8'h75); send(8'hF0); send(8'h75); idle(1);
    // Pause sequence, then extended down arrow.
    foreach (tbl[k]) if (k < 0) send(tbl[k]);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'hE0); send(8'h72); idle(2);
    send(8'hE0); send(8'hF0); send(8'h72); idle(1);
    // Stale prefix: E0, 16 idle cycles, then 72.
    send(8'hE0); idle(TO); send(8'h72); idle(2);
    send(8'hE0); send(8'hF0); send(8'h72); idle(1);
    // Reset in the middle of E0 F0 discards the prefix.
    send(8'hE0); send(8'hF0); cyc(0, 0, 8'h00); send(8'h75); idle(1);
    send(8'hE0); send(8'h75); send(8'h00); send(8'hE0); send(8'hE0); send(8'hF0);
    send(8'hE1); send(8'hFF); idle(2);

    // Randomized traffic that mixes prefixes, mapped codes and noise.
    for (int k = 0; k < 4000; k++) begin
      int r = $urandom_range(0, 999);
      if (r < 2) begin
        cyc(0, 0, 8'h00);
      end else if (r < 10) begin
        idle($urandom_range(TO - 2, TO + 2));
      end else if (r < 300) begin
        idle(1);
      end else if (r < 850) begin
        send(tbl[$urandom_range(0, 13)]);
      end else begin
        send(8'($urandom_range(0, 255)));
      end
    end

    idle(3);
    @(posedge clk_50);
    #2;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
